// File: rtl/mdc_tx_packer.sv
// Purpose: Hamming-encodes a 4x4 matrix plus mode and streams it to the MDC stage, one element per beat.
// Latency: load accepted at edge T -> beats on T+1..T+16; next load only after done_i plus GAP_CYC idle cycles.
// Backpressure: single-entry; ld_ready stays low from accept until the MDC reports done and the gap expires.
module mdc_tx_packer #(
    parameter int GAP_CYC = 1,
    parameter int ERR_EN  = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         ld_valid,
    output logic         ld_ready,
    input  logic [4:0]   ld_mode,
    input  logic [175:0] ld_matrix,
    input  logic [3:0]   ld_err_pos,
    input  logic         done_i,
    output logic         in_valid,
    output logic [14:0]  in_data,
    output logic [8:0]   in_mode
);

    typedef enum logic [1:0] {IDLE, SEND, WAIT, GAP} state_t;

    localparam logic [3:0] GAP_INIT = 4'(GAP_CYC - 1);

    state_t         state;
    state_t         state_nxt;
    logic [3:0]     cnt;
    logic [3:0]     cnt_nxt;
    logic [3:0]     gap;
    logic [3:0]     gap_nxt;
    logic           load;

    logic [4:0]     mode_q;
    logic [175:0]   mat_q;
    logic [3:0]     err_q;

    logic [10:0]    elem [16];
    logic [14:0]    dmask;
    logic [8:0]     mmask;
    logic [14:0]    data_cw;
    logic [8:0]     mode_cw;

    // Codeword layout MSB-first: {p1,p2,d,p4,d,d,d,p8,d...}; parity is even over positions sharing the index bit.
    function automatic logic [14:0] enc_elem(input logic [10:0] d);
        logic p1, p2, p4, p8;
        p1 = d[10] ^ d[9] ^ d[7] ^ d[6] ^ d[4] ^ d[2] ^ d[0];
        p2 = d[10] ^ d[8] ^ d[7] ^ d[5] ^ d[4] ^ d[1] ^ d[0];
        p4 = d[9]  ^ d[8] ^ d[7] ^ d[3] ^ d[2] ^ d[1] ^ d[0];
        p8 = d[6]  ^ d[5] ^ d[4] ^ d[3] ^ d[2] ^ d[1] ^ d[0];
        return {p1, p2, d[10], p4, d[9], d[8], d[7], p8, d[6], d[5], d[4], d[3], d[2], d[1], d[0]};
    endfunction

    function automatic logic [8:0] enc_mode(input logic [4:0] m);
        logic p1, p2, p4, p8;
        p1 = m[4] ^ m[3] ^ m[1] ^ m[0];
        p2 = m[4] ^ m[2] ^ m[1];
        p4 = m[3] ^ m[2] ^ m[1];
        p8 = m[0];
        return {p1, p2, m[4], p4, m[3], m[2], m[1], p8, m[0]};
    endfunction

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            gap   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            gap   <= gap_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gap_nxt   = gap;
        load      = 1'b0;
        case (state)
            IDLE: begin
                if (ld_valid && ld_ready) begin
                    load      = 1'b1;
                    state_nxt = SEND;
                    cnt_nxt   = '0;
                end
            end
            SEND: begin
                cnt_nxt = cnt + 4'd1;
                if (cnt == 4'd15) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (done_i) begin
                    state_nxt = GAP;
                    gap_nxt   = GAP_INIT;
                end
            end
            GAP: begin
                if (gap == 4'd0) begin
                    state_nxt = IDLE;
                end else begin
                    gap_nxt = gap - 4'd1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            mode_q <= '0;
            mat_q  <= '0;
            err_q  <= '0;
        end else if (load) begin
            mode_q <= ld_mode;
            mat_q  <= ld_matrix;
            err_q  <= (ERR_EN != 0) ? ld_err_pos : 4'd0;
        end
    end

    always_comb begin
        for (int k = 0; k < 16; k++) begin
            elem[k] = mat_q[11*k +: 11];
        end
    end

    // Position p maps to bit W-p; positions beyond the mode width leave the mode codeword clean.
    always_comb begin
        dmask = '0;
        mmask = '0;
        for (int p = 1; p <= 15; p++) begin
            dmask[15-p] = (err_q == 4'(p));
        end
        for (int p = 1; p <= 9; p++) begin
            mmask[9-p] = (err_q == 4'(p));
        end
    end

    assign data_cw = enc_elem(elem[cnt]) ^ dmask;
    assign mode_cw = enc_mode(mode_q) ^ mmask;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            ld_ready <= 1'b0;
            in_valid <= 1'b0;
            in_data  <= '0;
            in_mode  <= '0;
        end else begin
            ld_ready <= (state_nxt == IDLE);
            in_valid <= (state == SEND);
            in_data  <= (state == SEND) ? data_cw : 15'd0;
            in_mode  <= (state == SEND && cnt == 4'd0) ? mode_cw : 9'd0;
        end
    end

endmodule

// File: doc/mdc_tx_packer.md
Name: mdc_tx_packer

Overview:
- Upstream feeder for the matrix-determinant-calculator (MDC) stage.
- Accepts one 4x4 matrix of 11-bit signed elements plus a 5-bit mode in a single load handshake.
- Hamming-encodes the mode to 9 bits and each element to 15 bits (even parity).
- Streams the encoded words over 16 consecutive cycles in the MDC input format: in_valid, in_data, with in_mode on the first beat only.
- Holds off the next packet until the MDC reports completion, with optional single-bit error injection for decoder testing.

Parameters:
- GAP_CYC, 1: idle cycles after done_i before ld_ready re-asserts; legal range 1..15.
- ERR_EN, 1: 1 = error-injection logic present; 0 = ld_err_pos ignored, no flips.

Ports:
- clk  in  1  single clock; all flops on the rising edge.
- rst_n  in  1  asynchronous, active-high reset (asserted = 1).
- ld_valid  in  1  load request.
- ld_ready  out  1  block can accept a load.
- ld_mode  in  5  raw mode.
- ld_matrix  in  176  element k (k = row*4 + col) at [11k+10:11k], two's complement.
- ld_err_pos  in  4  codeword position to flip (1..15); 0 = no flip.
- done_i  in  1  MDC out_valid pulse.
- in_valid  out  1  stream beat valid.
- in_data  out  15  encoded element.
- in_mode  out  9  encoded mode, first beat only.

Behaviour:
- Reset (rst_n = 1, asynchronous): state IDLE, beat counter 0, gap counter 0, all outputs 0 immediately. ld_ready goes 1 on the first clock edge after release.
- States:
  - IDLE: ld_ready = 1. On ld_valid & ld_ready at a rising edge, capture ld_mode, ld_matrix, ld_err_pos (zeroed if ERR_EN = 0); go to SEND with cnt = 0.
  - SEND: 16 beats, cnt 0..15. At cnt = 15 go to WAIT.
  - WAIT: hold until done_i = 1, then go to GAP with gap = GAP_CYC - 1.
  - GAP: decrement gap each cycle; on gap = 0 go to IDLE.
- ld_ready is 0 in every state except IDLE.
- Latency:
  - Load accepted at edge T: in_valid = 1 registered from T+1 through T+16.
  - Beat j (j = 0..15) carries element j. in_data = 0 whenever in_valid = 0.
  - in_mode = encoded mode on beat 0 only; 0 on all other cycles.
- Encoding:
  - Codeword bit position p = 1..W, MSB first; in_data[14] = p1, in_mode[8] = p1.
  - Parity bits sit at p = 1, 2, 4, 8. Data bits fill the remaining positions MSB-first: element bit 10 -> p3 ... bit 0 -> p15; mode bit 4 -> p3 ... bit 0 -> p9.
  - Parity at 2^i = XOR of all positions with bit i set (even parity).
- Error injection:
  - If err_pos != 0, invert position err_pos in every data codeword of the packet.
  - The mode codeword is also flipped when err_pos <= 9; otherwise mode is sent clean.
  - Encoding and flip are combinational on captured data; the result is registered into the output flops.
- Boundary conditions:
  - done_i during IDLE, SEND or GAP: ignored.
  - done_i on the same cycle WAIT is entered (cnt = 15 edge): not counted; WAIT needs a done_i sampled while in WAIT.
  - ld_valid while not ready: ignored, no capture; the requester must hold it.
  - Reset mid-SEND: stream aborts at once, in_valid drops asynchronously, partial packet is discarded, no resume.
  - Two back-to-back packets are separated by at least GAP_CYC + 1 cycles after done_i.
- Widths: no arithmetic beyond the 4-bit beat counter (wraps 15 -> 0 only on the SEND exit) and the 4-bit gap counter.

Test Plan:
- Reset then load mode 5'b00000, all elements = 11'd1, err_pos 0 -> ld_ready 0 during send; 16 beats with in_data = 15'h6881; in_mode = 9'h000 on beat 0; in_valid low after beat 15.
- Load mode 5'b10000, element k = k -> in_mode = 9'h1C0 on beat 0 only; beat 1 in_data = 15'h6881, beat 0 in_data = 15'h0000; in_data = 0 outside beats.
- err_pos = 15, elements = 1, mode 5'b10000 -> every beat 15'h6880; mode unflipped, 9'h1C0. Repeat with ERR_EN = 0 -> 15'h6881.
- After a packet, pulse done_i 5 cycles later with GAP_CYC = 3 -> ld_ready rises exactly 3 cycles after the done_i edge. A second ld_valid held throughout is accepted on that edge.
- Assert rst_n at beat 7 -> in_valid, in_data, in_mode = 0 immediately. After release, a new load streams from beat 0; the stale done_i is not needed.
- done_i pulses during SEND and IDLE -> no state change; the block stays in WAIT until a later done_i.
